// File: rtl/qspi_resp_pkg.sv
// Shared types and constants for the QSPI responder.
package qspi_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RD_DATA,
    WR_DATA,
    IGNORE
  } state_e;

  typedef enum logic [1:0] {
    OP_READ,
    OP_QREAD,
    OP_PROG
  } op_e;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_QREAD = 8'h6B;
  localparam logic [7:0] CMD_PROG  = 8'h02;

  localparam logic [3:0] OE_SINGLE = 4'b0010;
  localparam logic [3:0] OE_QUAD   = 4'hF;

endpackage

// File: rtl/qspi_resp_sync.sv
// Input synchronizer for the QSPI pins with SCK edge and CSn fall pulses.
module qspi_resp_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sck_i,
  input  logic       csn_i,
  input  logic [3:0] sd_i,
  output logic       csn_o,
  output logic [3:0] sd_o,
  output logic       sck_rise_o,
  output logic       sck_fall_o,
  output logic       csn_fall_o
);

  // Bit 5 = csn, bit 4 = sck, bits 3:0 = sd.
  localparam logic [5:0] StageRst = 6'b100000;

  logic [5:0] stage_q [SyncStages];
  logic [5:0] stage_d [SyncStages];
  logic       sck_prev_q, sck_prev_d;
  logic       csn_prev_q, csn_prev_d;
  logic       sck_s;

  always_comb begin
    stage_d[0] = {csn_i, sck_i, sd_i};
    for (int unsigned i = 1; i < SyncStages; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  assign sck_s      = stage_q[SyncStages-1][4];
  assign csn_o      = stage_q[SyncStages-1][5];
  assign sd_o       = stage_q[SyncStages-1][3:0];
  assign sck_prev_d = sck_s;
  assign csn_prev_d = csn_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < SyncStages; i++) begin
        stage_q[i] <= StageRst;
      end
      sck_prev_q <= 1'b0;
      csn_prev_q <= 1'b1;
    end else begin
      for (int unsigned i = 0; i < SyncStages; i++) begin
        stage_q[i] <= stage_d[i];
      end
      sck_prev_q <= sck_prev_d;
      csn_prev_q <= csn_prev_d;
    end
  end

  assign sck_rise_o = sck_s & ~sck_prev_q;
  assign sck_fall_o = ~sck_s & sck_prev_q;
  assign csn_fall_o = ~csn_o & csn_prev_q;

endmodule

// File: rtl/qspi_resp.sv
// QSPI mode-0 responder: decodes READ/QREAD/PROGRAM and bridges to a byte-memory port.
module qspi_resp
  import qspi_resp_pkg::*;
#(
  parameter int unsigned AddrWidth   = 24,
  parameter int unsigned DummyCycles = 8,
  parameter int unsigned SyncStages  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sck_i,
  input  logic                 csn_i,
  input  logic [3:0]           sd_i,
  output logic [3:0]           sd_o,
  output logic [3:0]           sd_oe_o,
  output logic                 rd_req_o,
  output logic [AddrWidth-1:0] rd_addr_o,
  input  logic [7:0]           rd_data_i,
  output logic                 wr_valid_o,
  output logic [AddrWidth-1:0] wr_addr_o,
  output logic [7:0]           wr_data_o
);

  localparam int unsigned MaxCnt = (AddrWidth > DummyCycles)
                                   ? ((AddrWidth > 8) ? AddrWidth : 8)
                                   : ((DummyCycles > 8) ? DummyCycles : 8);
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  logic       csn_s, sck_rise, sck_fall, csn_fall;
  logic [3:0] sd_s;
  logic       unused_sd;

  qspi_resp_sync #(
    .SyncStages(SyncStages)
  ) u_sync (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .sck_i     (sck_i),
    .csn_i     (csn_i),
    .sd_i      (sd_i),
    .csn_o     (csn_s),
    .sd_o      (sd_s),
    .sck_rise_o(sck_rise),
    .sck_fall_o(sck_fall),
    .csn_fall_o(csn_fall)
  );

  // Only sd[0] carries host data; the quad lines are ours to drive.
  assign unused_sd = ^sd_s[3:1];

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [7:0]             shift_q, shift_d;
  logic                   cap_q, cap_d;
  logic [3:0]             sd_q, sd_d;
  logic [3:0]             oe_q, oe_d;
  logic                   rd_req_q, rd_req_d;
  logic [AddrWidth-1:0]   rd_addr_q, rd_addr_d;
  logic                   wr_valid_q, wr_valid_d;
  logic [AddrWidth-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]             wr_data_q, wr_data_d;

  logic [AddrWidth-1:0]   addr_shift, addr_inc;
  logic [7:0]             byte_shift;
  logic [CntW-1:0]        cnt_inc, data_last;

  always_comb begin
    addr_shift = {addr_q[AddrWidth-2:0], sd_s[0]};
    addr_inc   = addr_q + AddrWidth'(1);
    byte_shift = {shift_q[6:0], sd_s[0]};
    cnt_inc    = cnt_q + CntW'(1);
    data_last  = (op_q == OP_QREAD) ? CntW'(1) : CntW'(7);

    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    cap_d      = rd_req_q;
    sd_d       = sd_q;
    rd_req_d   = 1'b0;
    rd_addr_d  = rd_addr_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    // CSn high dominates any SCK edge seen in the same cycle.
    if (csn_s) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (csn_fall) begin
            state_d = CMD;
            cnt_d   = '0;
          end
        end
        CMD: begin
          if (sck_rise) begin
            shift_d = byte_shift;
            cnt_d   = cnt_inc;
            if (cnt_q == CntW'(7)) begin
              cnt_d = '0;
              case (byte_shift)
                CMD_READ:  begin op_d = OP_READ;  state_d = ADDR; end
                CMD_QREAD: begin op_d = OP_QREAD; state_d = ADDR; end
                CMD_PROG:  begin op_d = OP_PROG;  state_d = ADDR; end
                default:   state_d = IGNORE;
              endcase
            end
          end
        end
        ADDR: begin
          if (sck_rise) begin
            addr_d = addr_shift;
            cnt_d  = cnt_inc;
            if (cnt_q == CntW'(AddrWidth - 1)) begin
              cnt_d = '0;
              if (op_q != OP_PROG) begin
                rd_req_d  = 1'b1;
                rd_addr_d = addr_shift;
              end
              case (op_q)
                OP_READ:  state_d = RD_DATA;
                OP_QREAD: state_d = (DummyCycles == 0) ? RD_DATA : DUMMY;
                default:  state_d = WR_DATA;
              endcase
            end
          end
        end
        DUMMY: begin
          if (sck_rise) begin
            cnt_d = cnt_inc;
            if (cnt_q == CntW'(DummyCycles - 1)) begin
              cnt_d   = '0;
              state_d = RD_DATA;
            end
          end
        end
        RD_DATA: begin
          if (sck_fall) begin
            if (op_q == OP_QREAD) begin
              sd_d    = shift_q[7:4];
              shift_d = {shift_q[3:0], 4'h0};
            end else begin
              sd_d    = {2'b00, shift_q[7], 1'b0};
              shift_d = {shift_q[6:0], 1'b0};
            end
          end
          if (sck_rise) begin
            cnt_d = cnt_inc;
            if (cnt_q == data_last) begin
              cnt_d     = '0;
              addr_d    = addr_inc;
              rd_req_d  = 1'b1;
              rd_addr_d = addr_inc;
            end
          end
        end
        WR_DATA: begin
          if (sck_rise) begin
            shift_d = byte_shift;
            cnt_d   = cnt_inc;
            if (cnt_q == CntW'(7)) begin
              cnt_d      = '0;
              wr_valid_d = 1'b1;
              wr_addr_d  = addr_q;
              wr_data_d  = byte_shift;
              addr_d     = addr_inc;
            end
          end
        end
        default: ;
      endcase
      // Memory data arrives the cycle after the request; reload the shifter.
      if (cap_q) shift_d = rd_data_i;
    end

    oe_d = '0;
    if (state_d == RD_DATA) oe_d = (op_d == OP_QREAD) ? OE_QUAD : OE_SINGLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      op_q       <= OP_READ;
      cnt_q      <= '0;
      addr_q     <= '0;
      shift_q    <= '0;
      cap_q      <= 1'b0;
      sd_q       <= '0;
      oe_q       <= '0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      cap_q      <= cap_d;
      sd_q       <= sd_d;
      oe_q       <= oe_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign sd_o       = sd_q;
  assign sd_oe_o    = oe_q;
  assign rd_req_o   = rd_req_q;
  assign rd_addr_o  = rd_addr_q;
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;

endmodule
